// File: rtl/sound_vol_env_multi.sv
// sound_vol_env_multi
//   NUM_CH independent volume envelope engines sharing one 64 Hz envelope tick.
//   Each engine loads its start volume on start, then steps the volume up or
//   down once every P ticks (P = live num_envelope_sweeps). The volume saturates
//   at 0 / max. When a step is attempted beyond that limit, the engine raises
//   env_done and stops until the next start.
//
// Ports:
//   clk                  system clock
//   rst                  synchronous reset, active-high
//   clk_vol_env          envelope tick, one clk wide, shared by all channels
//   start[NUM_CH]        per-channel trigger, one clk wide
//   initial_volume       per-channel start volume, channel i at [i*VOL_W +: VOL_W]
//   envelope_increasing  per-channel direction, 1 = up
//   num_envelope_sweeps  per-channel period in ticks, channel i at [i*PER_W +: PER_W]; 0 = disabled
//   target_vol           per-channel current volume (registered)
//   env_done             per-channel flag, envelope hit its limit and stopped
//   dac_en               per-channel DAC power (combinational from live inputs)
module sound_vol_env_multi #(
  parameter int NUM_CH = 3,
  parameter int VOL_W  = 4,
  parameter int PER_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_vol_env,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH*VOL_W-1:0] initial_volume,
  input  logic [NUM_CH-1:0]       envelope_increasing,
  input  logic [NUM_CH*PER_W-1:0] num_envelope_sweeps,
  output logic [NUM_CH*VOL_W-1:0] target_vol,
  output logic [NUM_CH-1:0]       env_done,
  output logic [NUM_CH-1:0]       dac_en
);

  localparam logic [VOL_W-1:0] VOL_MAX = {VOL_W{1'b1}};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [VOL_W-1:0] init_vol;
      logic [PER_W-1:0] period;
      logic             increasing;

      logic [VOL_W-1:0] vol_reg, vol_next;
      logic [PER_W-1:0] timer_reg, timer_next;
      logic             done_reg, done_next;

      assign init_vol   = initial_volume[gi*VOL_W +: VOL_W];
      assign period     = num_envelope_sweeps[gi*PER_W +: PER_W];
      assign increasing = envelope_increasing[gi];

      always_comb begin
        vol_next   = vol_reg;
        timer_next = timer_reg;
        done_next  = done_reg;
        if (start[gi]) begin
          // Start has priority over a coincident tick.
          vol_next   = init_vol;
          timer_next = period;
          done_next  = 1'b0;
        end else if (clk_vol_env && (period != '0) && !done_reg) begin
          if (timer_reg > PER_W'(1)) begin
            timer_next = timer_reg - PER_W'(1);
          end else begin
            // timer of 0 or 1 both mean "step now". A timer of 0 happens when
            // the period goes from disabled to nonzero, so the first tick after
            // that change steps immediately. The reload uses the live period.
            timer_next = period;
            if (increasing) begin
              if (vol_reg == VOL_MAX) done_next = 1'b1;
              else                    vol_next  = vol_reg + VOL_W'(1);
            end else begin
              if (vol_reg == '0) done_next = 1'b1;
              else               vol_next  = vol_reg - VOL_W'(1);
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          vol_reg   <= '0;
          timer_reg <= '0;
          done_reg  <= 1'b0;
        end else begin
          vol_reg   <= vol_next;
          timer_reg <= timer_next;
          done_reg  <= done_next;
        end
      end

      assign target_vol[gi*VOL_W +: VOL_W] = vol_reg;
      assign env_done[gi]                  = done_reg;
      // The DAC stays powered unless the channel is set to fade down from silence.
      assign dac_en[gi]                    = (init_vol != '0) || increasing;
    end
  endgenerate

endmodule

// File: tb/tb_sound_vol_env_multi.sv
// tb_sound_vol_env_multi
//   Directed-vector bench for sound_vol_env_multi (NUM_CH=3, VOL_W=4, PER_W=3).
//   Expected values are hand-computed from the envelope rules.
//   Inputs change 1 ns after each rising edge, and outputs are checked at the same point.
module tb_sound_vol_env_multi;

  localparam int NUM_CH = 3;
  localparam int VOL_W  = 4;
  localparam int PER_W  = 3;

  logic                    clk;
  logic                    rst;
  logic                    clk_vol_env;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH*VOL_W-1:0] initial_volume;
  logic [NUM_CH-1:0]       envelope_increasing;
  logic [NUM_CH*PER_W-1:0] num_envelope_sweeps;
  logic [NUM_CH*VOL_W-1:0] target_vol;
  logic [NUM_CH-1:0]       env_done;
  logic [NUM_CH-1:0]       dac_en;

  int n_vectors = 0;
  int n_miscompares = 0;

  sound_vol_env_multi #(.NUM_CH(NUM_CH), .VOL_W(VOL_W), .PER_W(PER_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .clk_vol_env         (clk_vol_env),
    .start               (start),
    .initial_volume      (initial_volume),
    .envelope_increasing (envelope_increasing),
    .num_envelope_sweeps (num_envelope_sweeps),
    .target_vol          (target_vol),
    .env_done            (env_done),
    .dac_en              (dac_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vectors++;
    if (obs != exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int vol(input int ch);
    return int'(target_vol[ch*VOL_W +: VOL_W]);
  endfunction

  task automatic set_ch(input int ch, input int iv, input logic inc, input int p);
    initial_volume[ch*VOL_W +: VOL_W]      = VOL_W'(iv);
    envelope_increasing[ch]                = inc;
    num_envelope_sweeps[ch*PER_W +: PER_W] = PER_W'(p);
  endtask

  task automatic set_period(input int ch, input int p);
    num_envelope_sweeps[ch*PER_W +: PER_W] = PER_W'(p);
  endtask

  // One clock with the given start mask / tick, then pulses return low.
  task automatic cyc(input logic [NUM_CH-1:0] st, input logic tk);
    start       = st;
    clk_vol_env = tk;
    @(posedge clk);
    #1;
    start       = '0;
    clk_vol_env = 1'b0;
  endtask

  int exp_dec_vol [8] = '{3, 2, 2, 1, 1, 0, 0, 0};

  initial begin
    rst = 1'b1;
    start = '0;
    clk_vol_env = 1'b0;
    initial_volume = '0;
    envelope_increasing = '0;
    num_envelope_sweeps = '0;
    set_ch(0, 5, 1'b1, 2);
    set_ch(1, 9, 1'b0, 1);
    set_ch(2, 7, 1'b1, 3);

    // Reset overrides start and tick on every channel.
    cyc('1, 1'b1);
    check("reset_target_vol", int'(target_vol), 0);
    check("reset_env_done", int'(env_done), 0);
    rst = 1'b0;
    set_ch(1, 0, 1'b0, 0);
    set_ch(2, 0, 1'b0, 0);

    // Decrease on ch0: vol 3, P=2, 8 ticks.
    set_ch(0, 3, 1'b0, 2);
    cyc(3'b001, 1'b0);
    check("dec_start_vol", vol(0), 3);
    check("dec_start_done", int'(env_done[0]), 0);
    for (int t = 0; t < 8; t++) begin
      cyc('0, 1'b1);
      check($sformatf("dec_tick%0d_vol", t + 1), vol(0), exp_dec_vol[t]);
      check($sformatf("dec_tick%0d_done", t + 1), int'(env_done[0]), (t == 7) ? 1 : 0);
    end
    cyc('0, 1'b1);
    cyc('0, 1'b1);
    check("dec_after_done", int'(env_done[0]), 1);
    check("dec_after_vol", vol(0), 0);

    // Increase with saturation on ch1: vol 14, up, P=1.
    set_ch(1, 14, 1'b1, 1);
    cyc(3'b010, 1'b0);
    check("inc_start_vol", vol(1), 14);
    cyc('0, 1'b1);
    check("inc_tick1_vol", vol(1), 15);
    check("inc_tick1_done", int'(env_done[1]), 0);
    cyc('0, 1'b1);
    check("inc_tick2_vol", vol(1), 15);
    check("inc_tick2_done", int'(env_done[1]), 1);
    cyc('0, 1'b1);
    check("inc_tick3_vol", vol(1), 15);

    // Disabled envelope on ch2 (P=0), then dac_en.
    set_ch(2, 7, 1'b0, 0);
    cyc(3'b100, 1'b0);
    for (int t = 0; t < 10; t++) cyc('0, 1'b1);
    check("dis_vol", vol(2), 7);
    check("dis_done", int'(env_done[2]), 0);
    check("dac_en_nonzero", int'(dac_en[2]), 1);
    set_ch(2, 0, 1'b0, 0);
    #1;
    check("dac_en_zero_down", int'(dac_en[2]), 0);
    set_ch(2, 0, 1'b1, 0);
    #1;
    check("dac_en_zero_up", int'(dac_en[2]), 1);

    // Restart ch1 while done=1.
    set_ch(1, 5, 1'b0, 1);
    cyc(3'b010, 1'b0);
    check("restart_done", int'(env_done[1]), 0);
    check("restart_vol", vol(1), 5);

    // Start on ch0 coincident with a tick; ch1 steps in the same cycle.
    set_ch(0, 9, 1'b0, 2);
    cyc(3'b001, 1'b1);
    check("coll_ch0_vol", vol(0), 9);
    check("coll_ch0_done", int'(env_done[0]), 0);
    check("coll_ch1_vol", vol(1), 4);
    cyc('0, 1'b1);
    check("coll_next_ch0_vol", vol(0), 9);
    check("coll_next_ch1_vol", vol(1), 3);
    cyc('0, 1'b1);
    check("coll_step_ch0_vol", vol(0), 8);

    // Live period change on ch0: P=4, switch to 1 after two ticks.
    set_ch(0, 8, 1'b0, 4);
    cyc(3'b001, 1'b0);
    cyc('0, 1'b1);
    cyc('0, 1'b1);
    set_period(0, 1);
    cyc('0, 1'b1);
    check("live_tick3_vol", vol(0), 8);
    cyc('0, 1'b1);
    check("live_tick4_vol", vol(0), 7);
    cyc('0, 1'b1);
    check("live_tick5_vol", vol(0), 6);
    cyc('0, 1'b1);
    check("live_tick6_vol", vol(0), 5);

    // ch2: the period goes from 0 to 3 with timer=0, so it steps on the first tick (up).
    set_period(2, 3);
    cyc('0, 1'b1);
    check("p0_to_nz_vol", vol(2), 8);
    cyc('0, 1'b1);
    check("p0_to_nz_hold", vol(2), 8);

    // Reset in the middle of an envelope.
    rst = 1'b1;
    cyc(3'b001, 1'b1);
    rst = 1'b0;
    check("midrst_vol", int'(target_vol), 0);
    check("midrst_done", int'(env_done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
